// File: rtl/lbp_host_if.sv
// Bus bundle between lbp_host (slave) and the pixel source, LBP engine and
// result sink (master). IMG_LOG2 must match the lbp_host instance.
interface lbp_host_if #(
   parameter int IMG_LOG2 = 7
);
   localparam int AW = 2 * IMG_LOG2;

   logic          in_valid;
   logic [7:0]    in_data;
   logic          gray_ready;
   logic          gray_req;
   logic [AW-1:0] gray_addr;
   logic [7:0]    gray_data;
   logic          lbp_valid;
   logic [AW-1:0] lbp_addr;
   logic [7:0]    lbp_data;
   logic          finish;
   logic          out_valid;
   logic [AW-1:0] out_addr;
   logic [7:0]    out_data;
   logic          done;
   logic          err;

   modport master (
      output in_valid, in_data, gray_req, gray_addr,
             lbp_valid, lbp_addr, lbp_data, finish,
      input  gray_ready, gray_data, out_valid, out_addr, out_data, done, err
   );

   modport slave (
      input  in_valid, in_data, gray_req, gray_addr,
             lbp_valid, lbp_addr, lbp_data, finish,
      output gray_ready, gray_data, out_valid, out_addr, out_data, done, err
   );
endinterface

// File: rtl/lbp_host.sv
// LBP host: loads a gray image, serves it to the LBP engine, collects results and dumps them
// with a zeroed border. Define LBP_HOST_CHK_EN to enable the sticky protocol checker on err.
module lbp_host #(
   parameter int IMG_LOG2 = 7
) (
   input  logic      clk,
   input  logic      reset,
   lbp_host_if.slave bus
);
   localparam int SIDE = 1 << IMG_LOG2;
   localparam int AW   = 2 * IMG_LOG2;
   localparam int NPIX = 1 << AW;

   typedef enum logic [1:0] {LOAD, SERVE, DUMP, DONE} state_t;

   state_t        state, state_nxt;
   logic [7:0]    gray_mem [NPIX];
   logic [7:0]    res_mem  [NPIX];
   logic [AW-1:0] load_cnt;
   logic [AW-1:0] dump_cnt;
   logic          out_valid_q;
   logic [AW-1:0] out_addr_q;
   logic [7:0]    out_data_q;
   logic          load_we, res_we, last_beat, dump_issue;

   function automatic logic is_border(input logic [AW-1:0] a);
      logic [IMG_LOG2-1:0] row, col;
      row = a[AW-1:IMG_LOG2];
      col = a[IMG_LOG2-1:0];
      return (row == '0) || (&row) || (col == '0) || (&col);
   endfunction

   assign load_we    = reset && (state == LOAD)  && bus.in_valid;
   assign res_we     = reset && (state == SERVE) && bus.lbp_valid;
   assign last_beat  = out_valid_q && (&out_addr_q);
   // A new beat is issued every DUMP cycle except while the final address is on the bus.
   assign dump_issue = (state == DUMP) && !last_beat;

   always_ff @(posedge clk) begin
      if (!reset) state <= LOAD;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         LOAD:    if (load_we && (&load_cnt)) state_nxt = SERVE;
         SERVE:   if (bus.finish)             state_nxt = DUMP;
         DUMP:    if (last_beat)              state_nxt = DONE;
         default: state_nxt = state;
      endcase
   end

   // NOTE: the image arrays are deliberately left out of reset so they map onto plain RAM;
   // their contents survive a reset and only the control state restarts.
   always_ff @(posedge clk) begin
      if (load_we) gray_mem[load_cnt]     <= bus.in_data;
      if (res_we)  res_mem[bus.lbp_addr]  <= bus.lbp_data;
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         load_cnt    <= '0;
         dump_cnt    <= '0;
         out_valid_q <= 1'b0;
         out_addr_q  <= '0;
         out_data_q  <= '0;
      end else begin
         if (load_we) load_cnt <= load_cnt + AW'(1);
         if (dump_issue) begin
            out_valid_q <= 1'b1;
            out_addr_q  <= dump_cnt;
            out_data_q  <= is_border(dump_cnt) ? 8'h00 : res_mem[dump_cnt];
            dump_cnt    <= dump_cnt + AW'(1);
         end else begin
            out_valid_q <= 1'b0;
            out_addr_q  <= '0;
            out_data_q  <= '0;
         end
      end
   end

   assign bus.gray_ready = (state == SERVE);
   assign bus.gray_data  = gray_mem[bus.gray_addr];
   assign bus.out_valid  = out_valid_q;
   assign bus.out_addr   = out_addr_q;
   assign bus.out_data   = out_data_q;
   assign bus.done       = (state == DONE);

`ifdef LBP_HOST_CHK_EN
   localparam logic [AW:0] INTERIOR = (AW+1)'((SIDE - 2) * (SIDE - 2));

   logic [AW:0] wr_cnt;
   logic [AW:0] wr_total;
   logic        err_q;
   logic        violation;

   // The write landing in the finish cycle belongs to the SERVE phase count.
   assign wr_total  = wr_cnt + {{AW{1'b0}}, res_we};
   assign violation = (bus.lbp_valid && is_border(bus.lbp_addr))
                   || (bus.lbp_valid && (state != SERVE))
                   || (bus.gray_req  && (state != SERVE))
                   || ((state == SERVE) && bus.finish && (wr_total != INTERIOR));

   always_ff @(posedge clk) begin
      if (!reset) begin
         wr_cnt <= '0;
         err_q  <= 1'b0;
      end else begin
         if (res_we)    wr_cnt <= wr_total;
         if (violation) err_q  <= 1'b1;
      end
   end

   assign bus.err = err_q;
`else
   logic unused_chk;
   assign unused_chk = bus.gray_req;
   assign bus.err    = 1'b0;
`endif
endmodule
